// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and default sizing.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_LEN = 255;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, MAC drive and result port of the sequencer; master is the controller side.
interface mac_seq_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WIDTH_MAC = 2 * WIDTH
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     w_in;
    logic signed [WIDTH-1:0]     x_in;
    logic                        mac_en;
    logic                        mac_clr;
    logic signed [WIDTH-1:0]     mac_w;
    logic signed [WIDTH-1:0]     mac_x;
    logic        [WIDTH_MAC-1:0] mac_out;
    logic                        res_valid;
    logic                        res_ready;
    logic        [WIDTH_MAC-1:0] result;

    modport master (
        input  in_valid, w_in, x_in, mac_out, res_ready,
        output in_ready, mac_en, mac_clr, mac_w, mac_x, res_valid, result
    );

    modport slave (
        output in_valid, w_in, x_in, mac_out, res_ready,
        input  in_ready, mac_en, mac_clr, mac_w, mac_x, res_valid, result
    );
endinterface

// File: rtl/mac_beat_counter.sv
// Beat counter for the sequencer: counts accepted pairs and flags the final one.
module mac_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] limit,
    output logic             last
);
    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + LEN_W'(1);
        end
    end

    // Only meaningful while limit != 0; the controller never consults it otherwise.
    assign last = (count == limit - LEN_W'(1));
endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one MAC datapath through a length-len dot product and presents the captured sum.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WIDTH_MAC = 2 * WIDTH,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    mac_seq_ctrl_if.master   bus,
    output logic             busy,
    output logic             done
);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q;
    logic [WIDTH_MAC-1:0]   result_q;
    logic                   xfer, last, cnt_clr;

    assign xfer    = (state_q == ACCUM) && bus.in_valid;
    assign cnt_clr = (state_q != ACCUM) || abort || (xfer && last);

    mac_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (xfer),
        .limit (len_q),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                len_q <= (len > MAX_LEN_V) ? MAX_LEN_V : len;
            end
            if (state_q == DRAIN && !abort) begin
                result_q <= bus.mac_out;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.mac_en    = 1'b0;
        bus.mac_clr   = 1'b0;
        bus.mac_w     = '0;
        bus.mac_x     = '0;
        bus.res_valid = 1'b0;
        done          = 1'b0;
        busy          = (state_q != IDLE);
        unique case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: begin
                bus.mac_clr = 1'b1;
                state_d     = (len_q != '0) ? ACCUM : DRAIN;
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (xfer) begin
                    bus.mac_en = 1'b1;
                    bus.mac_w  = bus.w_in;
                    bus.mac_x  = bus.x_in;
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: state_d = HOLD;
            HOLD: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready && !abort) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort overrides every transition except from IDLE
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized self-checking bench for mac_seq_ctrl with a behavioural MAC and dot-product model.
module tb_mac_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] len_in = '0;
    logic       busy, done;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0, clr_cnt = 0, done_cnt = 0;

    logic signed [7:0] w_q[$];
    logic signed [7:0] x_q[$];
    longint acc = 0;

    mac_seq_ctrl_if #(.WIDTH(8), .WIDTH_MAC(16)) bus ();

    mac_seq_ctrl #(.WIDTH(8), .WIDTH_MAC(16), .MAX_LEN(255)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len_in),
        .abort (abort),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: full-precision accumulator, output truncated to the port width.
    always @(posedge clk) begin
        if (bus.mac_clr) acc <= 0;
        else if (bus.mac_en) acc <= acc + longint'(bus.mac_w) * longint'(bus.mac_x);
    end
    assign bus.mac_out = acc[15:0];

    always @(negedge clk) begin
        if (bus.mac_en) en_cnt++;
        if (bus.mac_clr) clr_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [15:0] exp_dot();
        int s = 0;
        foreach (w_q[i]) s += int'(w_q[i]) * int'(x_q[i]);
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        w_q.delete(); x_q.delete();
        for (int i = 0; i < n; i++) begin
            w_q.push_back(8'($urandom));
            x_q.push_back(8'($urandom));
        end
    endtask

    // Starts a run from IDLE and feeds w_q/x_q; returns the edge count (after the start edge)
    // at which res_valid first appears, or -1 on timeout.
    task automatic do_run(input int n, input int gap_at, input int gap_len, input int bub,
                          output int hold_edge, output int ready_gap_bad);
        int sent = 0, edges = 0, gap_left = 0;
        bit in_gap;
        hold_edge = -1; ready_gap_bad = 0;
        en_cnt = 0; clr_cnt = 0; done_cnt = 0;
        start = 1'b1; len_in = 8'(n);
        tick();
        start = 1'b0;
        while (edges < 300) begin
            in_gap = (gap_left > 0);
            if (sent < n && !in_gap && !(bub > 0 && $urandom_range(99) < bub)) begin
                bus.in_valid = 1'b1; bus.w_in = w_q[sent]; bus.x_in = x_q[sent];
            end else begin
                bus.in_valid = 1'b0; bus.w_in = 8'($urandom); bus.x_in = 8'($urandom);
            end
            @(negedge clk);
            if (in_gap) begin
                if (!bus.in_ready) ready_gap_bad++;
                gap_left--;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                if (sent == gap_at) gap_left = gap_len;
            end
            tick();
            edges++;
            if (bus.res_valid) begin
                hold_edge = edges;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_accept(output logic done_seen, output logic busy_after);
        bus.res_ready = 1'b1;
        @(negedge clk);
        done_seen = done;
        tick();
        bus.res_ready = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.w_in = 8'sd5; bus.x_in = 8'sd9; bus.res_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, bus.in_ready, bus.mac_en, bus.mac_clr, bus.res_valid,
             bus.mac_w, bus.mac_x, bus.result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b rv=%b mac_w=%0d result=%0d, required all 0",
                     busy, bus.res_valid, bus.mac_w, bus.result);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int he, bad; logic ds, ba;
        w_q = '{8'sd2, -8'sd1, 8'sd5}; x_q = '{8'sd3, 8'sd4, 8'sd5};
        do_run(3, 0, 0, 0, he, bad);
        checks++;
        if (he !== 5) begin errors++; $display("FAIL b2b_latency: hold at edge %0d required 5", he); end
        checks++;
        if (en_cnt !== 3) begin errors++; $display("FAIL b2b_en_count: %0d required 3", en_cnt); end
        checks++;
        if (bus.result !== 16'd27) begin errors++; $display("FAIL b2b_result: %0d required 27", bus.result); end
        do_accept(ds, ba);
        checks++;
        if (ds !== 1'b1 || done_cnt !== 1 || ba !== 1'b0) begin
            errors++; $display("FAIL b2b_done: done=%b count=%0d busy=%b required 1/1/0", ds, done_cnt, ba);
        end
    endtask

    task automatic test_bubbles();
        int he, bad; logic ds, ba;
        w_q = '{8'sd1, 8'sd1, 8'sd1, 8'sd1}; x_q = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        do_run(4, 2, 2, 0, he, bad);
        checks++;
        if (he !== 8 || en_cnt !== 4) begin
            errors++; $display("FAIL bubble_timing: hold edge %0d en %0d required 8 and 4", he, en_cnt);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bubble_in_ready: low %0d cycles required 0", bad); end
        checks++;
        if (bus.result !== 16'd4) begin errors++; $display("FAIL bubble_result: %0d required 4", bus.result); end
        do_accept(ds, ba);
    endtask

    task automatic test_len_zero();
        int he, bad; logic ds, ba;
        w_q.delete(); x_q.delete();
        do_run(0, 0, 0, 0, he, bad);
        checks++;
        if (he !== 2 || clr_cnt !== 1 || en_cnt !== 0) begin
            errors++; $display("FAIL len0_flow: hold %0d clr %0d en %0d required 2/1/0", he, clr_cnt, en_cnt);
        end
        checks++;
        if (bus.result !== 16'd0) begin errors++; $display("FAIL len0_result: %0d required 0", bus.result); end
        do_accept(ds, ba);
    endtask

    task automatic test_hold_backpressure();
        int he, bad; logic [15:0] exp;
        fill_random(3);
        exp = exp_dot();
        do_run(3, 0, 0, 0, he, bad);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2); len_in = 8'd2;
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || done !== 1'b0 || bus.result !== exp) begin
                errors++; $display("FAIL hold_stable: rv=%b done=%b result=%0d required 1/0/%0d",
                                   bus.res_valid, done, bus.result, exp);
            end
            tick();
        end
        start = 1'b1; bus.res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL hold_done: done=%b required 1", done); end
        tick();
        start = 1'b0; bus.res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: busy=%b required 0", busy); end
        tick();
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1) begin
            errors++; $display("FAIL hold_idle: busy=%b done_count=%0d required 0/1", busy, done_cnt);
        end
    endtask

    task automatic test_abort();
        int sent = 0, cyc = 0, he, bad; bit bad_seen = 0; logic ds, ba;
        fill_random(5);
        done_cnt = 0;
        start = 1'b1; len_in = 8'd5;
        tick();
        start = 1'b0;
        while (sent < 2 && cyc < 50) begin
            bus.in_valid = 1'b1; bus.w_in = w_q[sent]; bus.x_in = x_q[sent];
            @(negedge clk);
            if (bus.in_ready) sent++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b rv=%b sent=%0d required 0/0/2", busy, bus.res_valid, sent);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.res_valid || busy) bad_seen = 1;
        end
        checks++;
        if (bad_seen || done_cnt !== 0) begin
            errors++; $display("FAIL abort_no_result: stray=%b done_count=%0d required 0/0", bad_seen, done_cnt);
        end
        tick();
        w_q = '{-8'sd128, 8'sd127}; x_q = '{-8'sd128, -8'sd128};
        do_run(2, 0, 0, 0, he, bad);
        checks++;
        if (bus.result !== 16'd128) begin errors++; $display("FAIL abort_rerun: %0d required 128", bus.result); end
        do_accept(ds, ba);
    endtask

    task automatic test_async_reset();
        int cyc = 0, he, bad; logic ds, ba;
        fill_random(4);
        start = 1'b1; len_in = 8'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.w_in = 8'sd7; bus.x_in = 8'sd9;
        while (!bus.in_ready && cyc < 20) begin tick(); cyc++; end
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, bus.in_ready, bus.mac_en, bus.mac_clr, bus.res_valid, bus.mac_w, bus.mac_x, bus.result} !== '0) begin
            errors++; $display("FAIL async_reset: busy=%b ready=%b en=%b mac_w=%0d required all 0",
                               busy, bus.in_ready, bus.mac_en, bus.mac_w);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_idle: busy=%b required 0", busy); end
        w_q = '{8'sd7}; x_q = '{-8'sd3};
        do_run(1, 0, 0, 0, he, bad);
        checks++;
        if (bus.result !== 16'hFFEB || he !== 3) begin
            errors++; $display("FAIL async_rerun: result=%0d hold=%0d required 65515/3", bus.result, he);
        end
        do_accept(ds, ba);
    endtask

    task automatic test_random();
        int n, he, bad; logic [15:0] exp; logic ds, ba;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 9);
            fill_random(n);
            exp = exp_dot();
            do_run(n, 0, 0, 35, he, bad);
            checks++;
            if (bus.result !== exp || en_cnt !== n) begin
                errors++; $display("FAIL random_run%0d: result=%0d en=%0d required %0d/%0d",
                                   r, bus.result, en_cnt, exp, n);
            end
            do_accept(ds, ba);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.w_in = '0; bus.x_in = '0; bus.res_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_len_zero();
        test_hold_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
